// File: rtl/pcie_tx_req_arb.sv
// Arbitrates PRP MRd, DMA MRd and DMA MWr requests onto one TX TLP request port (PCIE_TX_ARB_PRP_PRIO_EN: PRP strict priority).
// Latency 1 cycle from request to tx_req; the grant is held until tx_req_ack, and MWr holds off new grants until its last payload beat.
module pcie_tx_req_arb #(
  parameter int C_PCIE_ADDR_WIDTH = 48
) (
  input  logic                         pcie_user_clk,
  input  logic                         pcie_user_rst,

  input  logic                         tx_prp_mrd_req,
  input  logic [7:0]                   tx_prp_mrd_tag,
  input  logic [12:2]                  tx_prp_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2] tx_prp_mrd_addr,
  output logic                         tx_prp_mrd_req_ack,

  input  logic                         tx_dma_mrd_req,
  input  logic [7:0]                   tx_dma_mrd_tag,
  input  logic [12:2]                  tx_dma_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2] tx_dma_mrd_addr,
  output logic                         tx_dma_mrd_req_ack,

  input  logic                         tx_dma_mwr_req,
  input  logic [7:0]                   tx_dma_mwr_tag,
  input  logic [12:2]                  tx_dma_mwr_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2] tx_dma_mwr_addr,
  output logic                         tx_dma_mwr_req_ack,
  output logic                         tx_dma_mwr_data_last,

  output logic                         tx_req,
  output logic [1:0]                   tx_type,
  output logic [7:0]                   tx_tag,
  output logic [12:2]                  tx_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2] tx_addr,
  input  logic                         tx_req_ack,
  input  logic                         tx_mwr_data_last,
  output logic                         tx_mwr_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    MWR_DATA = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_PRP = 2'b00;
  localparam logic [1:0] TYPE_MRD = 2'b01;
  localparam logic [1:0] TYPE_MWR = 2'b10;

  state_t                         state;
  logic [1:0]                     rr_ptr;
  logic [2:0]                     req_vec;
  logic                           win_vld;
  logic [1:0]                     win_idx;
  logic [1:0]                     rr_ptr_nxt;
  logic [7:0]                     win_tag;
  logic [12:2]                    win_len;
  logic [C_PCIE_ADDR_WIDTH-1:2]   win_addr;
  logic                           ack_ok;

  assign req_vec = {tx_dma_mwr_req, tx_dma_mrd_req, tx_prp_mrd_req};
  assign win_vld = |req_vec;

`ifdef PCIE_TX_ARB_PRP_PRIO_EN
  // PRP always wins; rr_ptr only ever selects between the two DMA queues
  always_comb begin
    win_idx = TYPE_PRP;
    if (req_vec[0])
      win_idx = TYPE_PRP;
    else if (req_vec[1] && req_vec[2])
      win_idx = (rr_ptr == TYPE_MWR) ? TYPE_MWR : TYPE_MRD;
    else if (req_vec[1])
      win_idx = TYPE_MRD;
    else if (req_vec[2])
      win_idx = TYPE_MWR;
  end

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (win_idx == TYPE_MRD)
      rr_ptr_nxt = TYPE_MWR;
    else if (win_idx == TYPE_MWR)
      rr_ptr_nxt = TYPE_MRD;
  end
`else
  always_comb begin
    win_idx = TYPE_PRP;
    case (rr_ptr)
      TYPE_PRP: begin
        if      (req_vec[0]) win_idx = TYPE_PRP;
        else if (req_vec[1]) win_idx = TYPE_MRD;
        else if (req_vec[2]) win_idx = TYPE_MWR;
      end
      TYPE_MRD: begin
        if      (req_vec[1]) win_idx = TYPE_MRD;
        else if (req_vec[2]) win_idx = TYPE_MWR;
        else if (req_vec[0]) win_idx = TYPE_PRP;
      end
      default: begin
        if      (req_vec[2]) win_idx = TYPE_MWR;
        else if (req_vec[0]) win_idx = TYPE_PRP;
        else if (req_vec[1]) win_idx = TYPE_MRD;
      end
    endcase
  end

  always_comb begin
    rr_ptr_nxt = TYPE_PRP;
    case (win_idx)
      TYPE_PRP: rr_ptr_nxt = TYPE_MRD;
      TYPE_MRD: rr_ptr_nxt = TYPE_MWR;
      default:  rr_ptr_nxt = TYPE_PRP;
    endcase
  end
`endif

  always_comb begin
    win_tag  = tx_prp_mrd_tag;
    win_len  = tx_prp_mrd_len;
    win_addr = tx_prp_mrd_addr;
    case (win_idx)
      TYPE_MRD: begin
        win_tag  = tx_dma_mrd_tag;
        win_len  = tx_dma_mrd_len;
        win_addr = tx_dma_mrd_addr;
      end
      TYPE_MWR: begin
        win_tag  = tx_dma_mwr_tag;
        win_len  = tx_dma_mwr_len;
        win_addr = tx_dma_mwr_addr;
      end
      default: ;
    endcase
  end

  // Registered tx_type doubles as the grant, so acks need no extra state
  assign ack_ok               = tx_req_ack && (state == REQ) && !pcie_user_rst;
  assign tx_prp_mrd_req_ack   = ack_ok && (tx_type == TYPE_PRP);
  assign tx_dma_mrd_req_ack   = ack_ok && (tx_type == TYPE_MRD);
  assign tx_dma_mwr_req_ack   = ack_ok && (tx_type == TYPE_MWR);
  assign tx_dma_mwr_data_last = tx_mwr_data_last && (state == MWR_DATA) && !pcie_user_rst;

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      state       <= IDLE;
      rr_ptr      <= TYPE_PRP;
      tx_req      <= 1'b0;
      tx_type     <= TYPE_PRP;
      tx_tag      <= '0;
      tx_len      <= '0;
      tx_addr     <= '0;
      tx_mwr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            tx_req  <= 1'b1;
            tx_type <= win_idx;
            tx_tag  <= win_tag;
            tx_len  <= win_len;
            tx_addr <= win_addr;
            rr_ptr  <= rr_ptr_nxt;
            state   <= REQ;
          end
        end
        REQ: begin
          if (tx_req_ack) begin
            tx_req <= 1'b0;
            if (tx_type == TYPE_MWR) begin
              tx_mwr_busy <= 1'b1;
              state       <= MWR_DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        MWR_DATA: begin
          if (tx_mwr_data_last) begin
            tx_mwr_busy <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_req_arb.sv
// Directed bench for pcie_tx_req_arb: grant order, hold-until-ack, MWr payload phase, reset abort.
module tb_pcie_tx_req_arb;

  localparam int AW = 48;

  logic          clk = 1'b0;
  logic          rst;
  logic          prp_req, mrd_req, mwr_req;
  logic [7:0]    prp_tag, mrd_tag, mwr_tag;
  logic [12:2]   prp_len, mrd_len, mwr_len;
  logic [AW-1:2] prp_addr, mrd_addr, mwr_addr;
  logic          prp_ack, mrd_ack, mwr_ack, dma_mwr_last;
  logic          tx_req;
  logic [1:0]    tx_type;
  logic [7:0]    tx_tag;
  logic [12:2]   tx_len;
  logic [AW-1:2] tx_addr;
  logic          tx_req_ack, tx_mwr_data_last, tx_mwr_busy;

  int n_cmp = 0;
  int n_err = 0;

  pcie_tx_req_arb #(.C_PCIE_ADDR_WIDTH(AW)) dut (
    .pcie_user_clk        (clk),
    .pcie_user_rst        (rst),
    .tx_prp_mrd_req       (prp_req),
    .tx_prp_mrd_tag       (prp_tag),
    .tx_prp_mrd_len       (prp_len),
    .tx_prp_mrd_addr      (prp_addr),
    .tx_prp_mrd_req_ack   (prp_ack),
    .tx_dma_mrd_req       (mrd_req),
    .tx_dma_mrd_tag       (mrd_tag),
    .tx_dma_mrd_len       (mrd_len),
    .tx_dma_mrd_addr      (mrd_addr),
    .tx_dma_mrd_req_ack   (mrd_ack),
    .tx_dma_mwr_req       (mwr_req),
    .tx_dma_mwr_tag       (mwr_tag),
    .tx_dma_mwr_len       (mwr_len),
    .tx_dma_mwr_addr      (mwr_addr),
    .tx_dma_mwr_req_ack   (mwr_ack),
    .tx_dma_mwr_data_last (dma_mwr_last),
    .tx_req               (tx_req),
    .tx_type              (tx_type),
    .tx_tag               (tx_tag),
    .tx_len               (tx_len),
    .tx_addr              (tx_addr),
    .tx_req_ack           (tx_req_ack),
    .tx_mwr_data_last     (tx_mwr_data_last),
    .tx_mwr_busy          (tx_mwr_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] acks();
    return 64'({mwr_ack, mrd_ack, prp_ack});
  endfunction

  // Expects a grant on the next edge, holds two cycles, acks, and completes MWr payload.
  task automatic do_grant(input int exp_type, input logic [7:0] exp_tag);
    tick;
    chk("grant_req", 64'(tx_req), 64'd1);
    chk("grant_type", 64'(tx_type), 64'(exp_type));
    chk("grant_tag", 64'(tx_tag), 64'(exp_tag));
    tick;
    chk("hold_req", 64'(tx_req), 64'd1);
    tx_req_ack = 1'b1;
    #1;
    chk("grant_ack", acks(), 64'(3'b001 << exp_type));
    tick;
    tx_req_ack = 1'b0;
    chk("req_drop", 64'(tx_req), 64'd0);
    if (exp_type == 2) begin
      chk("mwr_busy", 64'(tx_mwr_busy), 64'd1);
      tx_mwr_data_last = 1'b1;
      #1;
      chk("mwr_last_fwd", 64'(dma_mwr_last), 64'd1);
      tick;
      tx_mwr_data_last = 1'b0;
      chk("mwr_busy_clr", 64'(tx_mwr_busy), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    {prp_req, mrd_req, mwr_req} = 3'b000;
    prp_tag = 8'h00; mrd_tag = 8'h00; mwr_tag = 8'h00;
    prp_len = '0;    mrd_len = '0;    mwr_len = '0;
    prp_addr = '0;   mrd_addr = '0;   mwr_addr = '0;
    tx_req_ack = 1'b0;
    tx_mwr_data_last = 1'b0;
    tick;
    tick;

    // Reset state
    chk("rst_req", 64'(tx_req), 64'd0);
    chk("rst_type", 64'(tx_type), 64'd0);
    chk("rst_tag", 64'(tx_tag), 64'd0);
    chk("rst_len", 64'(tx_len), 64'd0);
    chk("rst_addr", 64'(tx_addr), 64'd0);
    chk("rst_busy", 64'(tx_mwr_busy), 64'd0);
    chk("rst_acks", acks(), 64'd0);
    rst = 1'b0;

    // Single PRP request
    prp_req = 1'b1; prp_tag = 8'h05; prp_len = 11'h010; prp_addr = 46'h1000;
    tick;
    chk("prp_req", 64'(tx_req), 64'd1);
    chk("prp_type", 64'(tx_type), 64'd0);
    chk("prp_tag", 64'(tx_tag), 64'h05);
    chk("prp_len", 64'(tx_len), 64'h010);
    chk("prp_addr", 64'(tx_addr), 64'h1000);
    chk("prp_noack", acks(), 64'd0);
    tick;
    chk("prp_hold", 64'(tx_req), 64'd1);
    tx_req_ack = 1'b1;
    #1;
    chk("prp_ack", acks(), 64'b001);
    tick;
    tx_req_ack = 1'b0;
    prp_req = 1'b0;
    chk("prp_ack_once", acks(), 64'd0);
    chk("prp_req_low", 64'(tx_req), 64'd0);
    tick;
    chk("no_stale_regrant", 64'(tx_req), 64'd0);

    // tx_mwr_data_last in IDLE is ignored
    tx_mwr_data_last = 1'b1;
    #1;
    chk("idle_last_fwd", 64'(dma_mwr_last), 64'd0);
    tick;
    tx_mwr_data_last = 1'b0;
    chk("idle_last_req", 64'(tx_req), 64'd0);
    chk("idle_last_busy", 64'(tx_mwr_busy), 64'd0);
    chk("idle_last_tag", 64'(tx_tag), 64'h05);
    chk("idle_last_len", 64'(tx_len), 64'h010);

    // Request withdrawn before ack: grant completes with latched fields
    mrd_req = 1'b1; mrd_tag = 8'h44; mrd_len = 11'h020; mrd_addr = 46'h2000;
    tick;
    chk("viol_type", 64'(tx_type), 64'd1);
    chk("viol_tag", 64'(tx_tag), 64'h44);
    mrd_req = 1'b0; mrd_tag = 8'h99; mrd_len = 11'h7ff;
    tick;
    chk("viol_hold_req", 64'(tx_req), 64'd1);
    chk("viol_hold_tag", 64'(tx_tag), 64'h44);
    chk("viol_hold_len", 64'(tx_len), 64'h020);
    tx_req_ack = 1'b1;
    #1;
    chk("viol_ack", acks(), 64'b010);
    tick;
    tx_req_ack = 1'b0;

    // All three requests held from reset
    rst = 1'b1;
    prp_tag = 8'h11; mrd_tag = 8'h22; mwr_tag = 8'h33;
    {prp_req, mrd_req, mwr_req} = 3'b111;
    tick;
    tick;
    chk("rst_held_req", 64'(tx_req), 64'd0);
    rst = 1'b0;
`ifdef PCIE_TX_ARB_PRP_PRIO_EN
    do_grant(0, 8'h11);
    do_grant(0, 8'h11);
    do_grant(0, 8'h11);
    prp_req = 1'b0;
    do_grant(1, 8'h22);
    do_grant(2, 8'h33);
    do_grant(1, 8'h22);
    prp_req = 1'b1;
    do_grant(0, 8'h11);
`else
    for (int i = 0; i < 6; i++) begin
      case (i % 3)
        0:       do_grant(0, 8'h11);
        1:       do_grant(1, 8'h22);
        default: do_grant(2, 8'h33);
      endcase
    end
`endif
    {prp_req, mrd_req, mwr_req} = 3'b000;

    // MWr payload phase blocks a later MRd
    mwr_req = 1'b1;
    tick;
    chk("mwr_type", 64'(tx_type), 64'd2);
    tx_req_ack = 1'b1;
    #1;
    chk("mwr_ack", acks(), 64'b100);
    tick;
    tx_req_ack = 1'b0;
    mwr_req = 1'b0;
    mrd_req = 1'b1;
    chk("mwr_phase_busy", 64'(tx_mwr_busy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mwr_phase_noreq", 64'(tx_req), 64'd0);
      chk("mwr_phase_nolast", 64'(dma_mwr_last), 64'd0);
    end
    tx_mwr_data_last = 1'b1;
    #1;
    chk("mwr_phase_last", 64'(dma_mwr_last), 64'd1);
    tick;
    tx_mwr_data_last = 1'b0;
    chk("mwr_end_busy", 64'(tx_mwr_busy), 64'd0);
    chk("mwr_end_req", 64'(tx_req), 64'd0);
    chk("mwr_end_last", 64'(dma_mwr_last), 64'd0);
    tick;
    chk("mrd_after_req", 64'(tx_req), 64'd1);
    chk("mrd_after_type", 64'(tx_type), 64'd1);
    chk("mrd_after_tag", 64'(tx_tag), 64'h22);
    tx_req_ack = 1'b1;
    tick;
    tx_req_ack = 1'b0;
    mrd_req = 1'b0;

    // Reset during MWR_DATA
    mwr_req = 1'b1;
    tick;
    tx_req_ack = 1'b1;
    tick;
    tx_req_ack = 1'b0;
    mwr_req = 1'b0;
    chk("rmwr_busy", 64'(tx_mwr_busy), 64'd1);
    rst = 1'b1;
    tx_mwr_data_last = 1'b1;
    #1;
    chk("rmwr_last_gated", 64'(dma_mwr_last), 64'd0);
    tick;
    rst = 1'b0;
    tx_mwr_data_last = 1'b0;
    chk("rmwr_busy_clr", 64'(tx_mwr_busy), 64'd0);
    chk("rmwr_req", 64'(tx_req), 64'd0);
    chk("rmwr_tag", 64'(tx_tag), 64'd0);
    chk("rmwr_acks", acks(), 64'd0);

    // Reset during REQ coinciding with ack
    mrd_req = 1'b1;
    tick;
    chk("rreq_type", 64'(tx_type), 64'd1);
    rst = 1'b1;
    tx_req_ack = 1'b1;
    #1;
    chk("rreq_no_ack", acks(), 64'd0);
    tick;
    rst = 1'b0;
    tx_req_ack = 1'b0;
    mrd_req = 1'b0;
    chk("rreq_req", 64'(tx_req), 64'd0);

    // Pointer back at PRP after reset
    {prp_req, mrd_req, mwr_req} = 3'b111;
    tick;
    chk("ptr_rst_req", 64'(tx_req), 64'd1);
    chk("ptr_rst_type", 64'(tx_type), 64'd0);
    {prp_req, mrd_req, mwr_req} = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_tx_req_arb.md
PCIE_TX_REQ_ARB -- requirements
Module: pcie_tx_req_arb

Interface
REQ-001 The block SHALL expose parameter C_PCIE_ADDR_WIDTH, default 48, the PCIe address width; address fields SHALL be [C_PCIE_ADDR_WIDTH-1:2].
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with the following ports:
- pcie_user_clk  in  1  sole clock; all logic rising-edge.
- pcie_user_rst  in  1  synchronous active-high reset.
- tx_prp_mrd_req / _tag / _len / _addr  in  1/8/[12:2]/addr  PRP memory-read request, held until ack.
- tx_prp_mrd_req_ack  out  1  PRP request accepted.
- tx_dma_mrd_req / _tag / _len / _addr  in  1/8/[12:2]/addr  DMA memory-read request, held until ack.
- tx_dma_mrd_req_ack  out  1  DMA read accepted.
- tx_dma_mwr_req / _tag / _len / _addr  in  1/8/[12:2]/addr  DMA memory-write request, held until ack.
- tx_dma_mwr_req_ack  out  1  DMA write accepted.
- tx_dma_mwr_data_last  out  1  forwarded end-of-write-payload strobe.
- tx_req  out  1  request to the TX TLP engine.
- tx_type  out  2  00=PRP MRd, 01=DMA MRd, 10=DMA MWr.
- tx_tag / tx_len / tx_addr  out  8/[12:2]/addr  granted request fields.
- tx_req_ack  in  1  TLP engine accepted tx_req.
- tx_mwr_data_last  in  1  TLP engine sent last MWr payload beat.
- tx_mwr_busy  out  1  MWr payload phase in progress.

Function
REQ-003 The block SHALL implement states IDLE, REQ and MWR_DATA.
REQ-004 In IDLE with at least one request asserted, the block SHALL select one winner, register its tag/len/addr/type into the tx_* outputs, and enter REQ; tx_req SHALL be high on the following cycle (latency 1).
REQ-005 Arbitration SHALL be round-robin over order PRP, DMA MRd, DMA MWr; the pointer SHALL advance to the entry after the winner at grant time.
REQ-006 In REQ, tx_req and all tx_* fields SHALL be held stable until tx_req_ack.
REQ-007 The winner's *_req_ack SHALL equal tx_req_ack gated by the grant, a combinational one-cycle pulse; the other acks SHALL stay 0.
REQ-008 On tx_req_ack, the block SHALL return to IDLE for read types and enter MWR_DATA for type 10, with tx_req low on the next cycle.
REQ-009 In MWR_DATA, tx_mwr_busy SHALL be 1 and no new grant SHALL be issued; on tx_mwr_data_last the block SHALL return to IDLE.
REQ-010 tx_dma_mwr_data_last SHALL equal tx_mwr_data_last AND (state==MWR_DATA); tx_mwr_data_last outside MWR_DATA SHALL be ignored.
REQ-011 A request deasserting before ack SHALL be a protocol violation; the granted request SHALL still complete with latched fields.
REQ-012 Requests arriving during REQ or MWR_DATA SHALL wait and SHALL NOT affect the latched fields.
REQ-013 A requester that drops its request on the cycle after ack SHALL NOT be re-granted from the stale request.

Reset
REQ-014 Reset SHALL force IDLE, the round-robin pointer to PRP, and tx_req, all *_req_ack, tx_mwr_busy, tx_dma_mwr_data_last, tx_type, tx_tag, tx_len and tx_addr to 0.
REQ-015 Reset asserted in REQ or MWR_DATA SHALL abandon the transaction, with no ack pulse, on the reset cycle.

Configuration
REQ-016 With PCIE_TX_ARB_PRP_PRIO_EN defined, a pending PRP request SHALL always win in IDLE, and round-robin SHALL apply only between DMA MRd and DMA MWr; without it, the three-way round-robin of REQ-005 SHALL apply.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Single PRP request (tag 0x05, len 0x10, addr 0x1000) -> tx_req 1 cycle later, tx_type 00, fields match; ack pulses tx_prp_mrd_req_ack once.
- All three requests held continuously from reset, ack after 2 cycles each -> grant order PRP, DMA MRd, DMA MWr, PRP ... (macro off).
- MWr granted, then DMA MRd requested -> no tx_req until tx_mwr_data_last; tx_dma_mwr_data_last pulses once; MRd is granted on the next IDLE cycle.
- With PCIE_TX_ARB_PRP_PRIO_EN and PRP re-requested after every ack -> PRP wins every arbitration; DMA requests win only when PRP is idle.
- Reset during MWR_DATA -> tx_mwr_busy 0 next cycle, state IDLE, pointer at PRP, no acks.
- tx_mwr_data_last pulsed in IDLE -> no output change.
